// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: ready/valid pipeline register with a 2-entry skid buffer, flush-to-bubble
// and a saturating bubble-cycle counter.
module pipe_stage_reg #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 128,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              accept, drain, load_main;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;
    assign load_main = ~main_valid | drain;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = (CLEAR_DATA && !main_valid) ? '0 : main_data;

    // A waiting skid beat always wins the main slot; in_ready is low then, so no accept collides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (load_main) begin
                main_valid <= skid_valid | accept;
                if (skid_valid) begin
                    main_ctrl  <= skid_ctrl;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
            end
            if (!main_valid && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: two configurations (hold data / 16-bit counter, clear data / 4-bit counter)
// driven in lockstep and compared against a queue-based reference model.
module tb_pipe_stage_reg;
    typedef logic [135:0] beat_t;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, out_ready;
    logic [7:0]   in_ctrl;
    logic [127:0] in_data;
    logic         in_ready0, out_valid0, in_ready1, out_valid1;
    logic [7:0]   out_ctrl0, out_ctrl1;
    logic [127:0] out_data0, out_data1;
    logic [15:0]  bubble_cnt0;
    logic [3:0]   bubble_cnt1;

    beat_t        q[$];
    logic [127:0] hold;
    logic [15:0]  cnt0;
    logic [3:0]   cnt1;
    int           tests = 0, fails = 0;
    logic [295:0] act;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CLEAR_DATA(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0), .bubble_cnt(bubble_cnt0)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CLEAR_DATA(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1), .bubble_cnt(bubble_cnt1)
    );

    assign act = {in_ready0, out_valid0, out_ctrl0, out_data0, bubble_cnt0,
                  in_ready1, out_valid1, out_ctrl1, out_data1, bubble_cnt1};

    // The stage behaves as a FIFO of depth 2 whose head is the visible output.
    function automatic logic [295:0] expv();
        logic         v, rdy;
        logic [7:0]   c;
        logic [127:0] d0, d1;
        v   = q.size() > 0;
        rdy = q.size() < 2;
        c   = v ? q[0][135:128] : 8'h00;
        d0  = v ? q[0][127:0] : hold;
        d1  = v ? q[0][127:0] : 128'h0;
        return {rdy, v, c, d0, cnt0, rdy, v, c, d1, cnt1};
    endfunction

    task automatic reset_model();
        q.delete();
        hold = '0;
        cnt0 = '0;
        cnt1 = '0;
    endtask

    task automatic tick();
        bit acc, drn;
        @(posedge clk);
        if (!rst_n) reset_model();
        else begin
            acc = in_valid && q.size() < 2;
            drn = q.size() > 0 && out_ready;
            if (q.size() == 0) begin
                if (cnt0 != 16'hFFFF) cnt0++;
                if (cnt1 != 4'hF) cnt1++;
            end
            if (flush) q.delete();
            else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back({in_ctrl, in_data});
            end
            if (q.size() > 0) hold = q[0][127:0];
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        reset_model();
        #1;
        tests++;
        if ({out_valid0, in_ready0, out_ctrl0, out_data0, bubble_cnt0} !== {1'b0, 1'b1, 8'h0, 128'h0, 16'h0}) begin
            fails++;
            $display("FAIL reset_outputs: got %h want %h", {out_valid0, in_ready0, out_ctrl0, out_data0, bubble_cnt0},
                     {1'b0, 1'b1, 8'h0, 128'h0, 16'h0});
        end
        tick();
        tick();
        tests++;
        if (act !== expv()) begin fails++; $display("FAIL reset_model: got %h want %h", act, expv()); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [15:0] b = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 8'h0F + 8'(i);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (i == 0) b = bubble_cnt0;
            tests++;
            if ({out_valid0, out_ctrl0, in_ready0, bubble_cnt0} !== {1'b1, 8'h0F + 8'(i), 1'b1, b}) begin
                fails++;
                $display("FAIL stream_beat%0d: got v=%b ctrl=%h rdy=%b cnt=%0d want v=1 ctrl=%h rdy=1 cnt=%0d",
                         i, out_valid0, out_ctrl0, in_ready0, bubble_cnt0, 8'h0F + 8'(i), b);
            end
            tests++;
            if (act !== expv()) begin fails++; $display("FAIL stream_model%0d: got %h want %h", i, act, expv()); end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (act !== expv()) begin fails++; $display("FAIL stream_tail: got %h want %h", act, expv()); end
    endtask

    task automatic fill_two(input logic [7:0] a, input logic [7:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = a;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_ctrl = b;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_two(8'hA1, 8'hB2);
        tick();
        tests++;
        if ({out_valid0, out_ctrl0, in_ready0} !== {1'b1, 8'hA1, 1'b0}) begin
            fails++;
            $display("FAIL bp_stall: got v=%b ctrl=%h rdy=%b want v=1 ctrl=a1 rdy=0", out_valid0, out_ctrl0, in_ready0);
        end
        tests++;
        if (act !== expv()) begin fails++; $display("FAIL bp_model: got %h want %h", act, expv()); end
        out_ready = 1'b1;
        tick();
        tests++;
        if ({out_valid0, out_ctrl0, in_ready0} !== {1'b1, 8'hB2, 1'b1}) begin
            fails++;
            $display("FAIL bp_release: got v=%b ctrl=%h rdy=%b want v=1 ctrl=b2 rdy=1", out_valid0, out_ctrl0, in_ready0);
        end
        tick();
        tests++;
        if (act !== expv() || out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL bp_empty: got %h want %h", act, expv());
        end
    endtask

    task automatic test_flush();
        fill_two(8'hC3, 8'hD4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 8'hE5;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if ({out_valid0, out_ctrl0, in_ready0, out_valid1, out_ctrl1} !== {1'b0, 8'h00, 1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL flush_now: got v=%b ctrl=%h rdy=%b want v=0 ctrl=00 rdy=1", out_valid0, out_ctrl0, in_ready0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out_valid0 !== 1'b0 || act !== expv()) begin
                fails++;
                $display("FAIL flush_after%0d: got %h want %h", i, act, expv());
            end
        end
    endtask

    task automatic test_clear_data();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h01;
        in_data   = 128'hDEAD;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        tests++;
        if ({out_data0, out_data1} !== {128'hDEAD, 128'hDEAD}) begin
            fails++;
            $display("FAIL clear_valid: got %h/%h want dead/dead", out_data0, out_data1);
        end
        tick();
        tests++;
        if ({out_valid0, out_data0, out_data1} !== {1'b0, 128'hDEAD, 128'h0}) begin
            fails++;
            $display("FAIL clear_idle: got v=%b %h/%h want v=0 dead/0", out_valid0, out_data0, out_data1);
        end
        tests++;
        if (act !== expv()) begin fails++; $display("FAIL clear_model: got %h want %h", act, expv()); end
    endtask

    task automatic test_saturate();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if ({bubble_cnt1, bubble_cnt0} !== {4'hF, 16'd20}) begin
            fails++;
            $display("FAIL saturate: got cnt4=%0d cnt16=%0d want 15/20", bubble_cnt1, bubble_cnt0);
        end
        tests++;
        if (act !== expv()) begin fails++; $display("FAIL saturate_model: got %h want %h", act, expv()); end
    endtask

    task automatic test_async_reset();
        fill_two(8'h77, 8'h88);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid0, out_ctrl0, out_data0, in_ready0, bubble_cnt0, out_valid1, bubble_cnt1} !==
            {1'b0, 8'h0, 128'h0, 1'b1, 16'h0, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL async_reset: got v=%b ctrl=%h data=%h rdy=%b cnt=%0d want all zero, rdy=1",
                     out_valid0, out_ctrl0, out_data0, in_ready0, bubble_cnt0);
        end
        reset_model();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out_valid0 !== 1'b0 || act !== expv()) begin
                fails++;
                $display("FAIL async_after%0d: got %h want %h", i, act, expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            tick();
            tests++;
            if (act !== expv()) begin fails++; $display("FAIL random%0d: got %h want %h", i, act, expv()); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_clear_data();
        test_saturate();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
